// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// Optional misaligned-access error reporting: define DMEM_MISALIGN_ERR_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rdata_o,
`ifdef DMEM_MISALIGN_ERR_EN
  output logic        err_o,
`endif
  output logic        stall_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_wr;
  logic            r_mis;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_idle;
  logic            w_accept;
  logic            w_go_resp;
  logic            w_addr_mis;
  logic            w_wr;
  logic            w_mis;
  logic [AW-1:0]   w_idx;
  logic [31:0]     w_wdata;
  logic            w_unused;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle & req_valid_i & req_ready_o;

`ifdef DMEM_MISALIGN_ERR_EN
  assign w_addr_mis = (addr_i[1:0] != 2'b00);
`else
  assign w_addr_mis = 1'b0;
`endif

  // With LATENCY==1 the access happens on the accept edge itself,
  // so the operands come straight from the inputs in IDLE.
  assign w_wr    = w_idle ? req_write_i       : r_wr;
  assign w_mis   = w_idle ? w_addr_mis        : r_mis;
  assign w_idx   = w_idle ? addr_i[AW+1:2]    : r_idx;
  assign w_wdata = w_idle ? wdata_i           : r_wdata;

  assign w_go_resp = (w_accept && (LATENCY == 1)) ||
                     ((r_state == S_BUSY) && (r_cnt == CW'(1)));

  assign stall_o  = req_valid_i & ~rsp_valid_o;
  assign w_unused = ^addr_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wr        <= 1'b0;
      r_mis       <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= '0;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rdata_o     <= '0;
`ifdef DMEM_MISALIGN_ERR_EN
      err_o       <= 1'b0;
`endif
    end else begin
      rsp_valid_o <= 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
      err_o       <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          req_ready_o <= 1'b1;
          if (w_accept) begin
            r_wr        <= req_write_i;
            r_mis       <= w_addr_mis;
            r_idx       <= addr_i[AW+1:2];
            r_wdata     <= wdata_i;
            r_cnt       <= CW'(LATENCY - 1);
            req_ready_o <= 1'b0;
            r_state     <= (LATENCY > 1) ? S_BUSY : S_RESP;
          end
        end
        S_BUSY: begin
          req_ready_o <= 1'b0;
          r_cnt       <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_RESP;
        end
        S_RESP: begin
          req_ready_o <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          req_ready_o <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
      if (w_go_resp) begin
        rsp_valid_o <= 1'b1;
        if (w_mis) begin
          rdata_o <= '0;
`ifdef DMEM_MISALIGN_ERR_EN
          err_o   <= 1'b1;
`endif
        end else if (!w_wr) begin
          rdata_o <= r_mem[w_idx];
        end
      end
    end
  end

  // Array is never reset; a reset edge also cancels a pending store.
  always_ff @(posedge clk_i) begin
    if (rst_i && w_go_resp && w_wr && !w_mis) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 4) driven
// with directed and random traffic against a word-array reference model.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [3];
  logic        rv    [3];
  logic        rw    [3];
  logic [31:0] ra    [3];
  logic [31:0] rd    [3];
  logic        rdy   [3];
  logic        rsp   [3];
  logic        stall [3];
  logic [31:0] rdat  [3];
  logic        err   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(256),
      .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 4))
    ) u_dut (
      .clk_i(clk),
      .rst_i(rst[g]),
      .req_valid_i(rv[g]),
      .req_ready_o(rdy[g]),
      .req_write_i(rw[g]),
      .addr_i(ra[g]),
      .wdata_i(rd[g]),
      .rsp_valid_o(rsp[g]),
      .rdata_o(rdat[g]),
`ifdef DMEM_MISALIGN_ERR_EN
      .err_o(err[g]),
`endif
      .stall_o(stall[g])
    );
`ifndef DMEM_MISALIGN_ERR_EN
    assign err[g] = 1'b0;
`endif
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl    [3][256];
  logic [31:0] exp_rd [3];

  function automatic int lat_of(input int u);
    case (u)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xact(input int u, input bit wr, input logic [31:0] a,
                      input logic [31:0] d);
    int n;
    int lat;
    int idx;
    bit mis;
    lat = lat_of(u);
    idx = int'((a >> 2) & 32'hFF);
`ifdef DMEM_MISALIGN_ERR_EN
    mis = (a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    n = 0;
    while (rdy[u] !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_idle", 32'(rdy[u]), 32'd1);
    rv[u] = 1'b1;
    rw[u] = wr;
    ra[u] = a;
    rd[u] = d;
    #1;
    chk("stall_req", 32'(stall[u]), 32'd1);
    @(posedge clk);
    #1;
    rw[u] = 1'($urandom);
    ra[u] = $urandom;
    rd[u] = $urandom;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (rsp[u] !== 1'b1) chk("stall_busy", 32'(stall[u]), 32'd1);
    end while (rsp[u] !== 1'b1 && n < lat + 4);
    chk("latency", 32'(n), 32'(lat));
    chk("rsp_valid", 32'(rsp[u]), 32'd1);
    chk("stall_rsp", 32'(stall[u]), 32'd0);
    chk("ready_rsp", 32'(rdy[u]), 32'd0);
    if (mis) exp_rd[u] = 32'd0;
    else if (wr) mdl[u][idx] = d;
    else exp_rd[u] = mdl[u][idx];
    chk("rdata", rdat[u], exp_rd[u]);
    chk("err_rsp", 32'(err[u]), 32'(mis));
    rv[u] = 1'b0;
    @(negedge clk);
    chk("rsp_pulse", 32'(rsp[u]), 32'd0);
    chk("err_pulse", 32'(err[u]), 32'd0);
    chk("ready_next", 32'(rdy[u]), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    int idx;
    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b0;
      rv[u]  = 1'b0;
      rw[u]  = 1'b0;
      ra[u]  = '0;
      rd[u]  = '0;
      exp_rd[u] = '0;
      for (int i = 0; i < 256; i++) mdl[u][i] = '0;
    end

    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk("rst_ready", 32'(rdy[u]), 32'd0);
      chk("rst_rsp", 32'(rsp[u]), 32'd0);
      chk("rst_rdata", rdat[u], 32'd0);
      chk("rst_err", 32'(err[u]), 32'd0);
      rst[u] = 1'b1;
    end
    @(negedge clk);
    for (int u = 0; u < 3; u++) chk("ready_release", 32'(rdy[u]), 32'd1);

    xact(0, 1'b1, 32'h10, 32'hDEADBEEF);
    xact(0, 1'b0, 32'h10, 32'h0);
    xact(0, 1'b1, 32'h400, 32'h1234);
    xact(0, 1'b0, 32'h000, 32'h0);

    xact(1, 1'b1, 32'h44, 32'h0BADF00D);
    xact(1, 1'b0, 32'h44, 32'h0);
    xact(1, 1'b0, 32'h44, 32'h0);

    xact(2, 1'b1, 32'h20, 32'h11111111);
    rv[2] = 1'b1;
    rw[2] = 1'b1;
    ra[2] = 32'h20;
    rd[2] = 32'hAAAA5555;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midop_busy_rsp", 32'(rsp[2]), 32'd0);
    rv[2]  = 1'b0;
    rst[2] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midop_rst_rsp", 32'(rsp[2]), 32'd0);
      chk("midop_rst_ready", 32'(rdy[2]), 32'd0);
    end
    rst[2] = 1'b1;
    exp_rd[2] = 32'd0;
    chk("midop_rdata", rdat[2], 32'd0);
    @(negedge clk);
    xact(2, 1'b0, 32'h20, 32'h0);

    xact(0, 1'b1, 32'h20, 32'hCAFEF00D);
    xact(0, 1'b1, 32'h22, 32'h1);
    xact(0, 1'b0, 32'h20, 32'h0);

    for (int u = 0; u < 3; u++) begin
      for (int i = 0; i < 16; i++) xact(u, 1'b1, 32'(i * 4), $urandom);
      for (int k = 0; k < 30; k++) begin
        r   = $urandom;
        idx = $urandom_range(0, 15);
        a   = (r & 32'hFFFF_FC00) | 32'(idx << 2);
        if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(0, 3));
        xact(u, 1'($urandom_range(0, 1)), a, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
